pipelined_controller: RTL and testbench

Decode-stage control unit with an integrated Decode→Execute control pipeline register for the pipelined RV32I core. It decodes the full RV32I integer ALU, branch and jump set, plus an optional M-extension subset. It flags illegal encodings and registers all control into the E stage with flush and bubble handling. Multi-cycle mul/div operations hold E via a small latency FSM that raises a stall request to the hazard unit.

---
 rtl/riscv_ctrl_pkg.sv | 57 +++++
 rtl/pipelined_controller_if.sv | 34 +++
 rtl/main_decoder.sv | 145 ++++++++++++++
 rtl/pipelined_controller.sv | 80 ++++++++
 tb/tb_pipelined_controller.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_ctrl_pkg.sv
// Shared RV32I control encodings: opcodes, funct7 qualifiers and the
// per-instruction control bundle carried from D into E.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_S    = 7'b0100011;
  localparam logic [6:0] OP_B    = 7'b1100011;
  localparam logic [6:0] OP_J    = 7'b1101111;
  localparam logic [6:0] OP_U    = 7'b0110111;

  localparam logic [6:0] F7_BASE   = 7'b0000000;
  localparam logic [6:0] F7_ALT    = 7'b0100000;
  localparam logic [6:0] F7_MULDIV = 7'b0000001;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000, ALU_SUB  = 4'b0001, ALU_AND  = 4'b0010, ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100, ALU_SLT  = 4'b0101, ALU_SLTU = 4'b0110, ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000, ALU_SRA  = 4'b1001, ALU_MUL  = 4'b1010, ALU_MULH = 4'b1011,
    ALU_DIV  = 4'b1100, ALU_DIVU = 4'b1101, ALU_REM  = 4'b1110, ALU_REMU = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00, RES_MEM = 2'b01, RES_PC4 = 2'b10, RES_IMM = 2'b11
  } result_src_e;

  typedef enum logic [1:0] {
    JMP_NONE = 2'b00, JMP_JAL = 2'b01, JMP_JALR = 2'b10
  } jump_e;

  typedef enum logic [2:0] {
    BR_NONE = 3'b000, BR_BEQ = 3'b001, BR_BNE  = 3'b010, BR_BLT = 3'b011,
    BR_BGE  = 3'b100, BR_BLTU = 3'b101, BR_BGEU = 3'b110
  } branch_e;

  typedef enum logic [2:0] {
    IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010, IMM_J = 3'b011, IMM_U = 3'b100
  } imm_src_e;

  typedef struct packed {
    logic        reg_write;
    result_src_e result_src;
    logic        mem_write;
    jump_e       jump;
    branch_e     branch;
    alu_op_e     alu_ctrl;
    logic        alu_src;
    imm_src_e    imm_src;
    logic        lui;
    logic        illegal;
  } ctrl_t;

  localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/pipelined_controller_if.sv
// D-stage instruction fields and handshake in, registered E-stage control out.
interface pipelined_controller_if #(
  parameter int ALU_CTRL_W = 4
);
  logic [6:0]            op;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  ValidD;
  logic                  FlushE;
  logic                  RegWriteE;
  logic [1:0]            ResultSrcE;
  logic                  MemWriteE;
  logic [1:0]            JumpE;
  logic [2:0]            BranchE;
  logic [ALU_CTRL_W-1:0] ALUControlE;
  logic                  ALUSrcE;
  logic [2:0]            ImmSrcE;
  logic                  LUIE;
  logic                  IllegalE;
  logic                  StallReq;
  logic [7:0]            IllegalCount;

  modport master (
    output op, funct3, funct7, ValidD, FlushE,
    input  RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
           ALUSrcE, ImmSrcE, LUIE, IllegalE, StallReq, IllegalCount
  );

  modport slave (
    input  op, funct3, funct7, ValidD, FlushE,
    output RegWriteE, ResultSrcE, MemWriteE, JumpE, BranchE, ALUControlE,
           ALUSrcE, ImmSrcE, LUIE, IllegalE, StallReq, IllegalCount
  );
endinterface

// File: rtl/main_decoder.sv
// Combinational RV32I (+ optional M subset) decoder producing the D-stage control
// bundle; any illegal encoding collapses to an all-zero bundle with illegal set.
module main_decoder
  import riscv_ctrl_pkg::*;
#(
  parameter int MULDIV_EN = 1
) (
  input  logic [6:0] op_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  output ctrl_t      ctrl_o,
  output logic       muldiv_o
);

  ctrl_t c;
  logic  bad;
  logic  md;

  always_comb begin
    c   = CTRL_BUBBLE;
    bad = 1'b0;
    md  = 1'b0;
    case (op_i)
      OP_R: begin
        c.reg_write = 1'b1;
        case (funct7_i)
          F7_BASE: begin
            case (funct3_i)
              3'b000: c.alu_ctrl = ALU_ADD;
              3'b001: c.alu_ctrl = ALU_SLL;
              3'b010: c.alu_ctrl = ALU_SLT;
              3'b011: c.alu_ctrl = ALU_SLTU;
              3'b100: c.alu_ctrl = ALU_XOR;
              3'b101: c.alu_ctrl = ALU_SRL;
              3'b110: c.alu_ctrl = ALU_OR;
              default: c.alu_ctrl = ALU_AND;
            endcase
          end
          F7_ALT: begin
            case (funct3_i)
              3'b000:  c.alu_ctrl = ALU_SUB;
              3'b101:  c.alu_ctrl = ALU_SRA;
              default: bad = 1'b1;
            endcase
          end
          F7_MULDIV: begin
            // mulhsu/mulhu have no ALU code, so they stay illegal even with M enabled
            if (MULDIV_EN != 0) begin
              md = 1'b1;
              case (funct3_i)
                3'b000:  c.alu_ctrl = ALU_MUL;
                3'b001:  c.alu_ctrl = ALU_MULH;
                3'b100:  c.alu_ctrl = ALU_DIV;
                3'b101:  c.alu_ctrl = ALU_DIVU;
                3'b110:  c.alu_ctrl = ALU_REM;
                3'b111:  c.alu_ctrl = ALU_REMU;
                default: bad = 1'b1;
              endcase
            end else begin
              bad = 1'b1;
            end
          end
          default: bad = 1'b1;
        endcase
      end
      OP_I: begin
        c.reg_write = 1'b1;
        c.alu_src   = 1'b1;
        c.imm_src   = IMM_I;
        case (funct3_i)
          3'b000: c.alu_ctrl = ALU_ADD;
          3'b010: c.alu_ctrl = ALU_SLT;
          3'b011: c.alu_ctrl = ALU_SLTU;
          3'b100: c.alu_ctrl = ALU_XOR;
          3'b110: c.alu_ctrl = ALU_OR;
          3'b111: c.alu_ctrl = ALU_AND;
          3'b001: begin
            c.alu_ctrl = ALU_SLL;
            bad        = (funct7_i != F7_BASE);
          end
          default: begin
            c.alu_ctrl = (funct7_i == F7_ALT) ? ALU_SRA : ALU_SRL;
            bad        = (funct7_i != F7_BASE) && (funct7_i != F7_ALT);
          end
        endcase
      end
      OP_LW: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_MEM;
        c.alu_src    = 1'b1;
        c.imm_src    = IMM_I;
        bad          = (funct3_i != 3'b010);
      end
      OP_S: begin
        c.mem_write = 1'b1;
        c.alu_src   = 1'b1;
        c.imm_src   = IMM_S;
        bad         = (funct3_i != 3'b010);
      end
      OP_B: begin
        c.alu_ctrl = ALU_SUB;
        c.imm_src  = IMM_B;
        case (funct3_i)
          3'b000:  c.branch = BR_BEQ;
          3'b001:  c.branch = BR_BNE;
          3'b100:  c.branch = BR_BLT;
          3'b101:  c.branch = BR_BGE;
          3'b110:  c.branch = BR_BLTU;
          3'b111:  c.branch = BR_BGEU;
          default: bad = 1'b1;
        endcase
      end
      OP_J: begin
        c.reg_write  = 1'b1;
        c.jump       = JMP_JAL;
        c.result_src = RES_PC4;
        c.imm_src    = IMM_J;
      end
      OP_JALR: begin
        c.reg_write  = 1'b1;
        c.jump       = JMP_JALR;
        c.result_src = RES_PC4;
        c.alu_src    = 1'b1;
        c.imm_src    = IMM_I;
        bad          = (funct3_i != 3'b000);
      end
      OP_U: begin
        c.reg_write  = 1'b1;
        c.result_src = RES_IMM;
        c.imm_src    = IMM_U;
        c.lui        = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    if (bad) begin
      c         = CTRL_BUBBLE;
      c.illegal = 1'b1;
      md        = 1'b0;
    end
  end

  assign ctrl_o   = c;
  assign muldiv_o = md;

endmodule

// File: rtl/pipelined_controller.sv
// Decode-stage controller with the D->E control register, mul/div occupancy FSM
// and a saturating illegal-instruction counter.
module pipelined_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 4,
  parameter int MULDIV_EN  = 1,
  parameter int MULDIV_LAT = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_controller_if.slave bus
);

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} md_state_e;

  // BUSY lasts until cnt hits LAT-2, giving LAT-1 stall cycles after the load
  localparam logic [3:0] CNT_LAST = 4'(MULDIV_LAT - 2);

  ctrl_t     ctrl_d;
  logic      muldiv_d;
  ctrl_t     e_q;
  md_state_e state_q;
  logic [3:0] cnt_q;
  logic [7:0] ill_cnt_q;

  main_decoder #(
    .MULDIV_EN (MULDIV_EN)
  ) u_dec (
    .op_i     (bus.op),
    .funct3_i (bus.funct3),
    .funct7_i (bus.funct7),
    .ctrl_o   (ctrl_d),
    .muldiv_o (muldiv_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_q       <= CTRL_BUBBLE;
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      ill_cnt_q <= '0;
    end else if (bus.FlushE) begin
      e_q     <= CTRL_BUBBLE;
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else if (state_q == S_BUSY) begin
      if (cnt_q == CNT_LAST) begin
        state_q <= S_IDLE;
      end else begin
        cnt_q <= cnt_q + 4'd1;
      end
    end else if (!bus.ValidD) begin
      e_q <= CTRL_BUBBLE;
    end else begin
      e_q <= ctrl_d;
      if (ctrl_d.illegal && (ill_cnt_q != 8'hFF)) begin
        ill_cnt_q <= ill_cnt_q + 8'd1;
      end
      if (muldiv_d && (MULDIV_LAT > 1)) begin
        state_q <= S_BUSY;
        cnt_q   <= '0;
      end
    end
  end

  assign bus.RegWriteE    = e_q.reg_write;
  assign bus.ResultSrcE   = e_q.result_src;
  assign bus.MemWriteE    = e_q.mem_write;
  assign bus.JumpE        = e_q.jump;
  assign bus.BranchE      = e_q.branch;
  assign bus.ALUControlE  = ALU_CTRL_W'(e_q.alu_ctrl);
  assign bus.ALUSrcE      = e_q.alu_src;
  assign bus.ImmSrcE      = e_q.imm_src;
  assign bus.LUIE         = e_q.lui;
  assign bus.IllegalE     = e_q.illegal;
  assign bus.StallReq     = (state_q == S_BUSY);
  assign bus.IllegalCount = ill_cnt_q;

endmodule

// File: tb/tb_pipelined_controller.sv
// Directed bench: table of single-cycle decode vectors plus hand-written mul/div,
// flush, saturation and asynchronous-reset sequences.
module tb_pipelined_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       valid;
  logic       flush;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipelined_controller_if #(.ALU_CTRL_W(4)) ifa ();
  pipelined_controller_if #(.ALU_CTRL_W(4)) ifb ();
  pipelined_controller_if #(.ALU_CTRL_W(4)) ifc ();

  assign ifa.op = op;  assign ifa.funct3 = f3;  assign ifa.funct7 = f7;
  assign ifa.ValidD = valid;  assign ifa.FlushE = flush;
  assign ifb.op = op;  assign ifb.funct3 = f3;  assign ifb.funct7 = f7;
  assign ifb.ValidD = valid;  assign ifb.FlushE = flush;
  assign ifc.op = op;  assign ifc.funct3 = f3;  assign ifc.funct7 = f7;
  assign ifc.ValidD = valid;  assign ifc.FlushE = flush;

  pipelined_controller #(.ALU_CTRL_W(4), .MULDIV_EN(1), .MULDIV_LAT(4)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  pipelined_controller #(.ALU_CTRL_W(4), .MULDIV_EN(0), .MULDIV_LAT(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  pipelined_controller #(.ALU_CTRL_W(4), .MULDIV_EN(1), .MULDIV_LAT(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  typedef struct packed {
    logic       rw;
    logic [1:0] rs;
    logic       mw;
    logic [1:0] j;
    logic [2:0] br;
    logic [3:0] alu;
    logic       as;
    logic [2:0] imm;
    logic       lui;
    logic       ill;
  } ctl_t;

  typedef struct {
    string name;
    int    op, f3, f7, valid, flush;
    ctl_t  exp;
  } vec_t;

  vec_t vecs[$];

  function automatic ctl_t C(int rw, int rs, int mw, int j, int br, int alu,
                             int as, int imm, int lui, int ill);
    return {1'(rw), 2'(rs), 1'(mw), 2'(j), 3'(br), 4'(alu), 1'(as), 3'(imm), 1'(lui), 1'(ill)};
  endfunction

  function automatic vec_t V(string n, int o, int a, int b, int v, int fl, ctl_t e);
    vec_t r;
    r.name = n; r.op = o; r.f3 = a; r.f7 = b; r.valid = v; r.flush = fl; r.exp = e;
    return r;
  endfunction

  function automatic ctl_t get_a();
    return {ifa.RegWriteE, ifa.ResultSrcE, ifa.MemWriteE, ifa.JumpE, ifa.BranchE,
            ifa.ALUControlE, ifa.ALUSrcE, ifa.ImmSrcE, ifa.LUIE, ifa.IllegalE};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int o, input int a, input int b, input int v, input int fl);
    op = 7'(o); f3 = 3'(a); f7 = 7'(b); valid = 1'(v); flush = 1'(fl);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  localparam int R = 'h33, LW = 'h03, I = 'h13, JR = 'h67, S = 'h23, B = 'h63, J = 'h6F, U = 'h37;
  localparam int BAD = 'h7F;

  int   exp_ill;
  ctl_t ADD_CTL;
  ctl_t ILL_CTL;
  logic [5:0] stall_bits;
  logic [5:0] div_bits;

  initial begin
    ADD_CTL = C(1,0,0,0,0,0,0,0,0,0);
    ILL_CTL = C(0,0,0,0,0,0,0,0,0,1);
    vecs.push_back(V("add",      R,  0, 'h00, 1, 0, ADD_CTL));
    vecs.push_back(V("sub",      R,  0, 'h20, 1, 0, C(1,0,0,0,0,1,0,0,0,0)));
    vecs.push_back(V("sra",      R,  5, 'h20, 1, 0, C(1,0,0,0,0,9,0,0,0,0)));
    vecs.push_back(V("bltu",     B,  6, 'h00, 1, 0, C(0,0,0,0,5,1,0,2,0,0)));
    vecs.push_back(V("jalr",     JR, 0, 'h00, 1, 0, C(1,2,0,2,0,0,1,0,0,0)));
    vecs.push_back(V("lw",       LW, 2, 'h00, 1, 0, C(1,1,0,0,0,0,1,0,0,0)));
    vecs.push_back(V("sw",       S,  2, 'h00, 1, 0, C(0,0,1,0,0,0,1,1,0,0)));
    vecs.push_back(V("lui",      U,  3, 'h12, 1, 0, C(1,3,0,0,0,0,0,4,1,0)));
    vecs.push_back(V("jal",      J,  7, 'h7F, 1, 0, C(1,2,0,1,0,0,0,3,0,0)));
    vecs.push_back(V("srai",     I,  5, 'h20, 1, 0, C(1,0,0,0,0,9,1,0,0,0)));
    vecs.push_back(V("xori",     I,  4, 'h55, 1, 0, C(1,0,0,0,0,4,1,0,0,0)));
    vecs.push_back(V("beq",      B,  0, 'h00, 1, 0, C(0,0,0,0,1,1,0,2,0,0)));
    vecs.push_back(V("sltu",     R,  3, 'h00, 1, 0, C(1,0,0,0,0,6,0,0,0,0)));
    vecs.push_back(V("br_f3_010",B,  2, 'h00, 1, 0, ILL_CTL));
    vecs.push_back(V("lw_f3_000",LW, 0, 'h00, 1, 0, ILL_CTL));
    vecs.push_back(V("r_alt_and",R,  7, 'h20, 1, 0, ILL_CTL));
    vecs.push_back(V("slli_alt", I,  1, 'h20, 1, 0, ILL_CTL));
    vecs.push_back(V("mulhsu",   R,  2, 'h01, 1, 0, ILL_CTL));
    vecs.push_back(V("jalr_f3_1",JR, 1, 'h00, 1, 0, ILL_CTL));
    vecs.push_back(V("unknown",  BAD,0, 'h00, 1, 0, ILL_CTL));
    vecs.push_back(V("bubble_v0",R,  0, 'h00, 0, 0, C(0,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(V("flush",    R,  0, 'h00, 1, 1, C(0,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(V("flush_ill",BAD,0, 'h00, 1, 1, C(0,0,0,0,0,0,0,0,0,0)));
    vecs.push_back(V("flush_v0", R,  0, 'h00, 0, 1, C(0,0,0,0,0,0,0,0,0,0)));

    drive(0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #12;
    chk("reset_ctl", 32'(get_a()), 32'd0);
    chk("reset_stall", 32'(ifa.StallReq), 32'd0);
    chk("reset_illcnt", 32'(ifa.IllegalCount), 32'd0);
    rst_n = 1'b1;

    exp_ill = 0;
    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].valid, vecs[i].flush);
      step();
      chk(vecs[i].name, 32'(get_a()), 32'(vecs[i].exp));
      if (vecs[i].exp.ill) exp_ill++;
      $display("[TB] vec %0d %s ctl=0x%05h", i, vecs[i].name, get_a());
    end
    chk("illcnt_table", 32'(ifa.IllegalCount), 32'(exp_ill));

    // div: LAT=4 unit stalls 3 cycles and holds E 4 cycles; M-disabled unit flags it
    drive(R, 4, 'h01, 1, 0);
    step();
    stall_bits = '0;
    div_bits   = '0;
    stall_bits[0] = ifa.StallReq;
    div_bits[0]   = (ifa.ALUControlE == 4'hC);
    chk("div_regwrite_a", 32'(ifa.RegWriteE), 32'd1);
    chk("div_ill_b", 32'(ifb.IllegalE), 32'd1);
    chk("div_regwrite_b", 32'(ifb.RegWriteE), 32'd0);
    chk("div_stall_b", 32'(ifb.StallReq), 32'd0);
    chk("div_alu_c", 32'(ifc.ALUControlE), 32'hC);
    chk("div_stall_c", 32'(ifc.StallReq), 32'd0);
    drive(R, 0, 0, 1, 0);
    for (int k = 1; k < 6; k++) begin
      step();
      stall_bits[k] = ifa.StallReq;
      div_bits[k]   = (ifa.ALUControlE == 4'hC);
      if (k == 1) chk("next_loads_c", 32'(ifc.ALUControlE), 32'd0);
      if (k == 4) chk("next_loads_a", 32'(get_a()), 32'(ADD_CTL));
    end
    chk("div_stall_pattern", 32'(stall_bits), 32'b000111);
    chk("div_hold_pattern", 32'(div_bits), 32'b001111);
    $display("[TB] div stall=%b hold=%b", stall_bits, div_bits);

    // flush on the second BUSY cycle aborts the op
    drive(R, 6, 'h01, 1, 0);
    step();
    chk("rem_busy1", 32'(ifa.StallReq), 32'd1);
    drive(R, 0, 0, 1, 0);
    step();
    chk("rem_busy2", 32'(ifa.StallReq), 32'd1);
    drive(R, 0, 0, 1, 1);
    step();
    chk("flush_abort_stall", 32'(ifa.StallReq), 32'd0);
    chk("flush_abort_ctl", 32'(get_a()), 32'd0);
    drive(R, 0, 0, 1, 0);
    step();
    chk("after_abort_add", 32'(get_a()), 32'(ADD_CTL));
    $display("[TB] flush abort done");

    // illegal counting: flushed ones ignored, then saturation at 255
    drive(BAD, 0, 0, 1, 1);
    repeat (5) step();
    chk("illcnt_flushed", 32'(ifa.IllegalCount), 32'(exp_ill));
    drive(BAD, 0, 0, 1, 0);
    repeat (10) step();
    chk("illcnt_plus10", 32'(ifa.IllegalCount), 32'(exp_ill + 10));
    chk("ill_ctl", 32'(get_a()), 32'(ILL_CTL));
    repeat (290) step();
    chk("illcnt_sat", 32'(ifa.IllegalCount), 32'd255);
    step();
    chk("illcnt_hold", 32'(ifa.IllegalCount), 32'd255);
    $display("[TB] illegal count %0d", ifa.IllegalCount);

    // asynchronous reset in the middle of a BUSY period
    drive(R, 0, 0, 0, 0);
    step();
    drive(R, 5, 'h01, 1, 0);
    step();
    chk("divu_busy", 32'(ifa.StallReq), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_ctl", 32'(get_a()), 32'd0);
    chk("async_rst_stall", 32'(ifa.StallReq), 32'd0);
    chk("async_rst_illcnt", 32'(ifa.IllegalCount), 32'd0);
    #4;
    rst_n = 1'b1;
    drive(R, 0, 0, 0, 0);
    step();
    chk("post_rst_stall", 32'(ifa.StallReq), 32'd0);
    chk("post_rst_illcnt", 32'(ifa.IllegalCount), 32'd0);
    drive(R, 0, 0, 1, 0);
    step();
    chk("post_rst_add", 32'(get_a()), 32'(ADD_CTL));
    chk("post_rst_nostall", 32'(ifa.StallReq), 32'd0);
    $display("[TB] async reset done");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

endmodule
